// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, init-sequencer state enum and a
// width helper reused by the controller.
package sdram_pkg;

    localparam logic [3:0] CMD_NOP         = 4'b0111;
    localparam logic [3:0] CMD_PRECHARGE   = 4'b0010;
    localparam logic [3:0] CMD_AUTOREFRESH = 4'b0001;
    localparam logic [3:0] CMD_LOAD_MODE   = 4'b0000;

    typedef enum logic [3:0] {
        ST_WAIT_PWR,
        ST_PRECHARGE,
        ST_WAIT_TRP,
        ST_AUTOREF,
        ST_WAIT_TRFC,
        ST_LOAD_MODE,
        ST_WAIT_TMRD,
        ST_LOAD_EMR,
        ST_WAIT_TEMRD,
        ST_DONE
    } init_state_t;

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/sdram_delay_cnt.sv
// Loadable saturating down-counter; expired_c is high while the count sits at zero.
module sdram_delay_cnt #(
    parameter int unsigned   W       = 8,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired_c
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= RST_VAL;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expired_c = (cnt == '0);

endmodule

// File: rtl/sdram_init_seq.sv
// SDRAM power-up/initialisation sequencer: power wait, precharge-all, N_REF
// auto-refreshes, load mode (and optionally extended mode), with software re-init.
module sdram_init_seq
    import sdram_pkg::*;
#(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned BA_W      = 2,
    parameter int unsigned T_POWER   = 15000,
    parameter int unsigned T_RP      = 2,
    parameter int unsigned T_RFC     = 7,
    parameter int unsigned T_MRD     = 2,
    parameter int unsigned N_REF     = 8,
    parameter int unsigned EMR_EN    = 0,
    parameter int unsigned MODE_WORD = 'h02C,
    parameter int unsigned EMR_WORD  = 'h000
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              reinit_req,
    output logic [3:0]        init_cmd,
    output logic [BA_W-1:0]   init_ba,
    output logic [ADDR_W-1:0] init_addr,
    output logic              init_busy,
    output logic              init_done
);

    localparam int unsigned CNT_W = $clog2(max4(T_POWER, T_RP, T_RFC, T_MRD)) + 1;
    localparam int unsigned REF_W = $clog2(N_REF) + 1;
    localparam init_state_t AFTER_MRD = (EMR_EN != 0) ? ST_LOAD_EMR : ST_DONE;

    init_state_t       state;
    init_state_t       state_next;
    logic [REF_W-1:0]  ref_cnt;
    logic              ref_clr;
    logic              ref_inc;
    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_val;
    logic              cnt_expired;
    logic [3:0]        cmd_c;
    logic [BA_W-1:0]   ba_c;
    logic [ADDR_W-1:0] addr_c;

    sdram_delay_cnt #(
        .W       (CNT_W),
        .RST_VAL (CNT_W'(T_POWER - 1))
    ) u_delay (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .load      (cnt_load),
        .load_val  (cnt_val),
        .expired_c (cnt_expired)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= ST_WAIT_PWR;
        end else begin
            state <= state_next;
        end
    end

    // Command states last one cycle; a delay of 1 lets them chain without a wait state.
    always_comb begin
        state_next = state;
        ref_inc    = 1'b0;
        cmd_c      = CMD_NOP;
        ba_c       = '1;
        addr_c     = '1;
        case (state)
            ST_WAIT_PWR: begin
                if (cnt_expired) state_next = ST_PRECHARGE;
            end
            ST_PRECHARGE: begin
                cmd_c      = CMD_PRECHARGE;
                state_next = cnt_expired ? ST_AUTOREF : ST_WAIT_TRP;
            end
            ST_WAIT_TRP: begin
                if (cnt_expired) state_next = ST_AUTOREF;
            end
            ST_AUTOREF, ST_WAIT_TRFC: begin
                if (state == ST_AUTOREF) cmd_c = CMD_AUTOREFRESH;
                if (cnt_expired) begin
                    if (ref_cnt < REF_W'(N_REF - 1)) begin
                        state_next = ST_AUTOREF;
                        ref_inc    = 1'b1;
                    end else begin
                        state_next = ST_LOAD_MODE;
                    end
                end else if (state == ST_AUTOREF) begin
                    state_next = ST_WAIT_TRFC;
                end
            end
            ST_LOAD_MODE: begin
                cmd_c      = CMD_LOAD_MODE;
                ba_c       = '0;
                addr_c     = ADDR_W'(MODE_WORD);
                state_next = cnt_expired ? AFTER_MRD : ST_WAIT_TMRD;
            end
            ST_WAIT_TMRD: begin
                if (cnt_expired) state_next = AFTER_MRD;
            end
            ST_LOAD_EMR: begin
                cmd_c      = CMD_LOAD_MODE;
                ba_c       = BA_W'(2);
                addr_c     = ADDR_W'(EMR_WORD);
                state_next = cnt_expired ? ST_DONE : ST_WAIT_TEMRD;
            end
            ST_WAIT_TEMRD: begin
                if (cnt_expired) state_next = ST_DONE;
            end
            ST_DONE: begin
                if (reinit_req) state_next = ST_PRECHARGE;
            end
            default: state_next = ST_WAIT_PWR;
        endcase

        ref_clr  = (state_next == ST_PRECHARGE);
        cnt_load = 1'b1;
        case (state_next)
            ST_PRECHARGE:              cnt_val = CNT_W'(T_RP - 1);
            ST_AUTOREF:                cnt_val = CNT_W'(T_RFC - 1);
            ST_LOAD_MODE, ST_LOAD_EMR: cnt_val = CNT_W'(T_MRD - 1);
            default: begin
                cnt_load = 1'b0;
                cnt_val  = '0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ref_cnt <= '0;
        end else if (ref_clr) begin
            ref_cnt <= '0;
        end else if (ref_inc) begin
            ref_cnt <= ref_cnt + REF_W'(1);
        end
    end

    // Outputs trail the state by one cycle.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            init_cmd  <= CMD_NOP;
            init_ba   <= '1;
            init_addr <= '1;
            init_busy <= 1'b1;
            init_done <= 1'b0;
        end else begin
            init_cmd  <= cmd_c;
            init_ba   <= ba_c;
            init_addr <= addr_c;
            init_busy <= (state != ST_DONE);
            init_done <= (state == ST_DONE);
        end
    end

endmodule

// File: tb/tb_sdram_init_seq.sv
// Bench for sdram_init_seq: four parameterisations run side by side against a
// schedule model built from the command timing rules.
module tb_sdram_init_seq;

    localparam int NEVER = 1 << 30;

    logic sys_clk    = 1'b0;
    logic sys_rst_n  = 1'b1;
    logic reinit_req = 1'b0;

    int cyc         = 0;
    int vectors     = 0;
    int miscompares = 0;
    int base [4];
    bit pre  [4];

    logic [3:0]  cmd  [4];
    logic [1:0]  ba   [4];
    logic        busy [4];
    logic        done [4];
    logic [11:0] a0, a1, a2;
    logic [12:0] a3;
    logic [20:0] obs  [4];

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    sdram_init_seq #(.T_POWER(20)) u0 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .reinit_req(reinit_req),
        .init_cmd(cmd[0]), .init_ba(ba[0]), .init_addr(a0),
        .init_busy(busy[0]), .init_done(done[0]));

    sdram_init_seq #(.T_POWER(20), .N_REF(1), .T_RFC(3)) u1 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .reinit_req(reinit_req),
        .init_cmd(cmd[1]), .init_ba(ba[1]), .init_addr(a1),
        .init_busy(busy[1]), .init_done(done[1]));

    sdram_init_seq #(.T_POWER(20), .T_MRD(3), .EMR_EN(1), .EMR_WORD('h040)) u2 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .reinit_req(reinit_req),
        .init_cmd(cmd[2]), .init_ba(ba[2]), .init_addr(a2),
        .init_busy(busy[2]), .init_done(done[2]));

    sdram_init_seq #(.ADDR_W(13), .BA_W(2), .T_POWER(10), .T_RP(1), .T_RFC(1),
                     .T_MRD(1), .N_REF(3)) u3 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .reinit_req(reinit_req),
        .init_cmd(cmd[3]), .init_ba(ba[3]), .init_addr(a3),
        .init_busy(busy[3]), .init_done(done[3]));

    assign obs[0] = {busy[0], done[0], cmd[0], ba[0], 1'b0, a0};
    assign obs[1] = {busy[1], done[1], cmd[1], ba[1], 1'b0, a1};
    assign obs[2] = {busy[2], done[2], cmd[2], ba[2], 1'b0, a2};
    assign obs[3] = {busy[3], done[3], cmd[3], ba[3], a3};

    function automatic void cfg(input int i, output int aw, output int tp, output int rp,
                                output int rfc, output int mrd, output int nref,
                                output bit emr, output int modew, output int emrw);
        aw = 12; tp = 20; rp = 2; rfc = 7; mrd = 2; nref = 8; emr = 0;
        modew = 'h02C; emrw = 'h000;
        case (i)
            1: begin nref = 1; rfc = 3; end
            2: begin mrd = 3; emr = 1; emrw = 'h040; end
            3: begin aw = 13; tp = 10; rp = 1; rfc = 1; mrd = 1; nref = 3; end
            default: ;
        endcase
    endfunction

    // Expected {busy, done, cmd, ba, addr} at cycle n for a sequence whose
    // PRECHARGE lands on cycle b; pd is the done level before that.
    function automatic logic [20:0] model(input int i, input int b, input bit pd, input int n);
        int aw, tp, rp, rfc, mrd, nref, modew, emrw, t, lm, last;
        bit emr, dn;
        logic [3:0]  c;
        logic [1:0]  bb;
        logic [12:0] ad;
        cfg(i, aw, tp, rp, rfc, mrd, nref, emr, modew, emrw);
        c  = 4'b0111;
        bb = 2'b11;
        ad = (aw == 13) ? 13'h1FFF : 13'h0FFF;
        t    = n - b;
        lm   = rp + nref * rfc;
        last = emr ? lm + mrd : lm;
        if (t < 0) begin
            dn = pd;
        end else begin
            dn = (t >= last + mrd);
            if (t == 0) c = 4'b0010;
            else if (t >= rp && t < lm && ((t - rp) % rfc) == 0) c = 4'b0001;
            else if (t == lm) begin c = 4'b0000; bb = 2'b00; ad = 13'(modew); end
            else if (emr && t == lm + mrd) begin c = 4'b0000; bb = 2'b10; ad = 13'(emrw); end
        end
        return {!dn, dn, c, bb, ad};
    endfunction

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic start_power_up();
        int aw, tp, rp, rfc, mrd, nref, modew, emrw;
        bit emr;
        for (int i = 0; i < 4; i++) begin
            cfg(i, aw, tp, rp, rfc, mrd, nref, emr, modew, emrw);
            base[i] = cyc + tp + 1;
            pre[i]  = 1'b0;
        end
    endtask

    task automatic take_req();
        logic [20:0] m;
        for (int i = 0; i < 4; i++) begin
            m = model(i, base[i], pre[i], cyc);
            if (m[19]) begin
                base[i] = cyc + 1;
                pre[i]  = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        logic [20:0] want;
        for (int i = 0; i < 4; i++) begin base[i] = NEVER; pre[i] = 1'b0; end
        #1 sys_rst_n = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step();
            for (int i = 0; i < 4; i++) begin
                want = model(i, base[i], pre[i], cyc);
                vectors++;
                if (obs[i] !== want) begin
                    miscompares++;
                    $display("FAIL reset dut%0d cyc=%0d got=%h want=%h", i, cyc, obs[i], want);
                end
            end
        end
        #($urandom_range(1, 4));
        sys_rst_n = 1'b1;
        start_power_up();
    endtask

    task automatic test_power_up();
        logic [20:0] want;
        for (int k = 0; k < 100; k++) begin
            step();
            for (int i = 0; i < 4; i++) begin
                want = model(i, base[i], pre[i], cyc);
                vectors++;
                if (obs[i] !== want) begin
                    miscompares++;
                    $display("FAIL power_up dut%0d cyc=%0d got=%h want=%h", i, cyc, obs[i], want);
                end
            end
        end
    endtask

    task automatic test_reinit();
        logic [20:0] want;
        int req_k;
        req_k = int'($urandom_range(0, 4));
        for (int k = 0; k < 100; k++) begin
            reinit_req = (k == req_k);
            step();
            for (int i = 0; i < 4; i++) begin
                want = model(i, base[i], pre[i], cyc);
                vectors++;
                if (obs[i] !== want) begin
                    miscompares++;
                    $display("FAIL reinit dut%0d cyc=%0d got=%h want=%h", i, cyc, obs[i], want);
                end
            end
            if (reinit_req) take_req();
        end
        reinit_req = 1'b0;
    endtask

    // Restart everything, then pulse again at an offset into dut0's sequence
    // where it is busy; dut0 must ignore it.
    task automatic test_reinit_ignored(input string tag, input int lo, input int hi);
        logic [20:0] want;
        int target;
        target = NEVER;
        for (int k = 0; k < 110; k++) begin
            reinit_req = (k == 0) || (cyc + 1 == target);
            step();
            for (int i = 0; i < 4; i++) begin
                want = model(i, base[i], pre[i], cyc);
                vectors++;
                if (obs[i] !== want) begin
                    miscompares++;
                    $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", tag, i, cyc, obs[i], want);
                end
            end
            if (reinit_req) take_req();
            if (k == 0) target = base[0] + int'($urandom_range(lo, hi));
        end
        reinit_req = 1'b0;
    endtask

    task automatic test_reset_mid_refresh();
        logic [20:0] want;
        int stop;
        stop = NEVER;
        for (int k = 0; k < 200 && cyc < stop; k++) begin
            reinit_req = (k == 0);
            step();
            for (int i = 0; i < 4; i++) begin
                want = model(i, base[i], pre[i], cyc);
                vectors++;
                if (obs[i] !== want) begin
                    miscompares++;
                    $display("FAIL mid_pre dut%0d cyc=%0d got=%h want=%h", i, cyc, obs[i], want);
                end
            end
            if (reinit_req) take_req();
            if (k == 0) stop = base[0] + 2 + 2 * 7 + 2;
        end
        reinit_req = 1'b0;
        #($urandom_range(1, 6));
        sys_rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin base[i] = NEVER; pre[i] = 1'b0; end
        #1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) step();
            for (int i = 0; i < 4; i++) begin
                want = model(i, base[i], pre[i], cyc);
                vectors++;
                if (obs[i] !== want) begin
                    miscompares++;
                    $display("FAIL mid_rst dut%0d cyc=%0d got=%h want=%h", i, cyc, obs[i], want);
                end
            end
        end
        #($urandom_range(1, 4));
        sys_rst_n = 1'b1;
        start_power_up();
        test_power_up();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_power_up();
        test_reinit();
        test_reinit_ignored("midref", 23, 29);
        test_reinit_ignored("done_edge", 59, 59);
        test_reset_mid_refresh();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
